// File: rtl/baby_store_controller.sv
// Word sequencer between the Baby's 32-bit store port and eight 1024x4 SRAMs on one shared bus.
// Optional feature macro: STORE_VERIFY_EN adds a read-back verify pass after every write.
module baby_store_controller #(
  parameter int ADDR_WIDTH    = 5,
  parameter int SETUP_CYCLES  = 1,
  parameter int PULSE_CYCLES  = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  verify_err,
  output logic [9:0]            sram_addr,
  output logic                  sram_cs_n,
  output logic                  sram_we_n,
  inout  wire  [31:0]           sram_dq
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_LATCH, V_ACCESS, V_CHECK
  } state_t;

  localparam int MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_SP > ACCESS_CYCLES) ? MAX_SP : ACCESS_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_done;
  logic               r_verr;
  logic [31:0]        r_rdata;
  logic [31:0]        r_wdata;
  logic [9:0]         r_addr;
  logic               r_cs_n;
  logic               r_we_n;
  logic               r_oe;

  logic               w_setup_last;
  logic               w_pulse_last;
  logic               w_access_last;

  assign w_setup_last  = (r_cnt == CNT_W'(SETUP_CYCLES - 1));
  assign w_pulse_last  = (r_cnt == CNT_W'(PULSE_CYCLES - 1));
  assign w_access_last = (r_cnt == CNT_W'(ACCESS_CYCLES - 1));

  // The bus is released whenever the controller is not in a write state.
  assign sram_dq    = r_oe ? r_wdata : 'z;
  assign ready      = r_ready;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign verify_err = r_verr;
  assign sram_addr  = r_addr;
  assign sram_cs_n  = r_cs_n;
  assign sram_we_n  = r_we_n;

  // Every strobe is computed from the next state, so all SRAM pins come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_verr  <= 1'b0;
      r_rdata <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_cs_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      r_done <= 1'b0;
      r_verr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= 10'(req_addr);
            r_wdata <= req_wdata;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_cs_n  <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe    <= req_write;
            r_state <= req_write ? W_SETUP : R_ACCESS;
          end
        end
        W_SETUP: begin
          if (w_setup_last) begin
            r_cnt   <= '0;
            r_we_n  <= 1'b0;
            r_state <= W_PULSE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        W_PULSE: begin
          if (w_pulse_last) begin
            r_cnt   <= '0;
            r_we_n  <= 1'b1;
`ifndef STORE_VERIFY_EN
            r_done  <= 1'b1;
`endif
            r_state <= W_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        W_HOLD: begin
          r_oe <= 1'b0;
`ifdef STORE_VERIFY_EN
          r_cnt   <= '0;
          r_state <= V_ACCESS;
`else
          r_cs_n  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
`endif
        end
        R_ACCESS: begin
          if (w_access_last) begin
            r_rdata <= sram_dq;
            r_done  <= 1'b1;
            r_state <= R_LATCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_LATCH: begin
          r_cs_n  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
`ifdef STORE_VERIFY_EN
        V_ACCESS: begin
          if (w_access_last) begin
            r_rdata <= sram_dq;
            r_done  <= 1'b1;
            r_verr  <= (sram_dq != r_wdata);
            r_state <= V_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        V_CHECK: begin
          r_cs_n  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
`endif
        default: begin
          r_cs_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_oe    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baby_store_controller.sv
// Self-checking bench for baby_store_controller: directed steps plus random traffic
// checked against a word-array store model and cycle latencies derived from the timing rules.
`timescale 1ns/1ps
module tb_baby_store_controller;

  localparam int AW = 5;
  localparam int S  = 1;
  localparam int P  = 2;
  localparam int A  = 2;
`ifdef STORE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int W_DONE  = VERIFY ? (S + P + A + 2) : (S + P + 1);
  localparam int W_READY = W_DONE + 1;
  localparam int R_DONE  = A + 1;
  localparam int R_READY = A + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          ready;
  logic          done;
  logic [31:0]   rdata;
  logic          verify_err;
  logic [9:0]    sram_addr;
  logic          sram_cs_n;
  logic          sram_we_n;
  wire  [31:0]   sram_dq;

  baby_store_controller #(
    .ADDR_WIDTH(AW), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .ACCESS_CYCLES(A)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready), .done(done),
    .rdata(rdata), .verify_err(verify_err), .sram_addr(sram_addr),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_dq(sram_dq)
  );

  always #5 clk = ~clk;

  // SRAM bank: the bench drives the bus only in phases where the controller is reading.
  logic [31:0] bank [1024];
  logic [31:0] stuck_mask = 32'hFFFF_FFFF;
  logic        tb_drv = 1'b0;
  assign sram_dq = (tb_drv && !sram_cs_n && sram_we_n) ? bank[sram_addr] : 'z;

  always @(posedge clk)
    if (!sram_cs_n && !sram_we_n) bank[sram_addr] <= sram_dq & stuck_mask;

  // Reference store and observable state.
  logic [31:0] ref_mem [32];
  logic [31:0] cur_rdata = '0;
  int errors = 0;
  int checks = 0;
  int issued = 0;
  int aborted = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      if (req_valid && ready) acc_cnt++;
      if (done) done_cnt++;
    end
  end

  always @(negedge clk)
    if (!reset && !sram_we_n) check("we_n_needs_cs", {31'b0, sram_cs_n}, 32'd0);

  // One transaction, entered and left at a falling edge. hold keeps req_valid high
  // with junk fields while busy; pulse_busy raises req_valid for one busy cycle.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input bit hold, input bit pulse_busy);
    int done_at = -1;
    int ready_at = -1;
    int we_lo = 0;
    logic [31:0] exp_after;
    logic        exp_verr;
    for (int k = 0; k < 50 && !ready; k++) @(negedge clk);
    check("ready_before_req", {31'b0, ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    tb_drv = !wr;
    issued++;
    if (wr) begin
      ref_mem[a] = d & stuck_mask;
      exp_after  = VERIFY ? (d & stuck_mask) : cur_rdata;
      exp_verr   = VERIFY && ((d & stuck_mask) != d);
    end else begin
      exp_after = ref_mem[a];
      exp_verr  = 1'b0;
    end
    @(posedge clk);
    #1;
    req_valid = hold;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    for (int n = 1; n <= W_READY + 4; n++) begin
      @(negedge clk);
      if (pulse_busy) req_valid = (n == 2);
      if (wr && n == S + P + 2) tb_drv = 1'b1;
      if (!sram_we_n) begin
        we_lo++;
        check("dq_during_we", sram_dq, d);
      end
      check("verr_only_with_done", {31'b0, verify_err & ~done}, 32'd0);
      if (done) begin
        if (done_at < 0) done_at = n;
        check("rdata_at_done", rdata, exp_after);
        check("verify_err_at_done", {31'b0, verify_err}, {31'b0, exp_verr});
      end else if (done_at < 0) begin
        check("rdata_held", rdata, cur_rdata);
      end
      if (ready) begin
        ready_at = n;
        check("cs_n_idle", {31'b0, sram_cs_n}, 32'd1);
        break;
      end
      check("cs_n_busy", {31'b0, sram_cs_n}, 32'd0);
      check("sram_addr", {22'b0, sram_addr}, {27'b0, a});
    end
    check(wr ? "write_done_cycle" : "read_done_cycle", done_at, wr ? W_DONE : R_DONE);
    check(wr ? "write_ready_cycle" : "read_ready_cycle", ready_at, wr ? W_READY : R_READY);
    if (wr) check("we_n_low_cycles", we_lo, P);
    if (pulse_busy) req_valid = 1'b0;
    cur_rdata = exp_after;
    tb_drv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [31:0]   rd;
    for (int i = 0; i < 1024; i++) bank[i] = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_verify_err", {31'b0, verify_err}, 32'd0);
    check("rst_sram_addr", {22'b0, sram_addr}, 32'd0);
    check("rst_cs_n", {31'b0, sram_cs_n}, 32'd1);
    check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    do_txn(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    check("read_deadbeef", rdata, 32'hDEADBEEF);
    do_txn(1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0);
    do_txn(1'b1, 5'd31, 32'h0F0F0F0F, 1'b0, 1'b0);
    do_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("read_addr0", rdata, 32'h12345678);
    do_txn(1'b0, 5'd31, 32'h0, 1'b0, 1'b0);
    check("read_addr31", rdata, 32'h0F0F0F0F);

    // req_valid held high, alternating write then read of the same address.
    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom);
      rd = $urandom;
      do_txn(1'b1, ra, rd, 1'b1, 1'b0);
      do_txn(1'b0, ra, 32'h0, 1'b1, 1'b0);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of the write pulse.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 32'hCAFEF00D;
    issued++;
    aborted++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 20 && sram_we_n; k++) @(negedge clk);
    check("reached_w_pulse", {31'b0, sram_we_n}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_cs_n", {31'b0, sram_cs_n}, 32'd1);
    check("midrst_we_n", {31'b0, sram_we_n}, 32'd1);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_verify_err", {31'b0, verify_err}, 32'd0);
    check("midrst_ready", {31'b0, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cur_rdata = '0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, ready}, 32'd1);
    do_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 5'd7, 32'h7777AAAA, 1'b0, 1'b0);

    // Busy pulses on req_valid must be ignored.
    do_txn(1'b0, 5'd31, 32'h0, 1'b0, 1'b1);
    do_txn(1'b1, 5'd12, 32'h55AA33CC, 1'b0, 1'b1);
    do_txn(1'b0, 5'd12, 32'h0, 1'b0, 1'b0);

    // Chip 0 stuck at zero: verify flags it only when the verify pass exists.
    stuck_mask = 32'hFFFF_FFF0;
    do_txn(1'b1, 5'd9, 32'h0000000F, 1'b0, 1'b0);
    stuck_mask = 32'hFFFF_FFFF;
    do_txn(1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
    check("stuck_readback", rdata, 32'h0);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), AW'($urandom), $urandom, 1'b0, 1'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    check("accept_count", acc_cnt, issued);
    check("done_count", done_cnt, issued - aborted);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
